// File: rtl/de_stage_reg.sv
// Decode-to-execute pipeline register: IR, PC, operand channels and delay-slot flag, with E-stage exception merge.
// Optional build macro DE_STAGE_PERF_EN adds saturating hold/bubble event counters.
module de_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned EXC_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     hold,
  input  logic                     bubble,
  input  logic                     valid_d,
  input  logic [DATA_W-1:0]        ir_d,
  input  logic [DATA_W-1:0]        pc_d,
  input  logic                     bd_d,
  input  logic [EXC_W-1:0]         exc_d,
  input  logic [NUM_CH*DATA_W-1:0] ch_d,
  input  logic                     over,
  output logic                     valid_e,
  output logic [DATA_W-1:0]        ir_e,
  output logic [DATA_W-1:0]        pc_e,
  output logic                     bd_e,
  output logic [NUM_CH*DATA_W-1:0] ch_e,
`ifdef DE_STAGE_PERF_EN
  output logic [31:0]              hold_cnt,
  output logic [31:0]              bubble_cnt,
`endif
  output logic [EXC_W-1:0]         exc_e
);

  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_t;

  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4);
  localparam logic [EXC_W-1:0] EXC_ADES = EXC_W'(5);
  localparam logic [EXC_W-1:0] EXC_OV   = EXC_W'(12);

  act_t                     w_act;
  logic                     r_valid;
  logic [DATA_W-1:0]        r_ir;
  logic [DATA_W-1:0]        r_pc;
  logic                     r_bd;
  logic [EXC_W-1:0]         r_exc;
  logic [NUM_CH*DATA_W-1:0] r_ch;

  always_comb begin
    w_act = ACT_LOAD;
    if (flush) begin
      w_act = ACT_FLUSH;
    end else if (hold) begin
      w_act = ACT_HOLD;
    end else if (bubble) begin
      w_act = ACT_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ir    <= '0;
      r_pc    <= '0;
      r_bd    <= 1'b0;
      r_exc   <= '0;
      r_ch    <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid <= 1'b0;
          r_ir    <= '0;
          r_pc    <= '0;
          r_bd    <= 1'b0;
          r_exc   <= '0;
          r_ch    <= '0;
        end
        ACT_HOLD: begin
        end
        default: begin
          r_valid <= valid_d;
          r_ir    <= ir_d;
          r_pc    <= pc_d;
          r_bd    <= bd_d;
          r_exc   <= exc_d;
          r_ch    <= ch_d;
        end
      endcase
    end
  end

  assign valid_e = r_valid;
  assign ir_e    = r_ir;
  assign pc_e    = r_pc;
  assign bd_e    = r_bd;
  assign ch_e    = r_ch;

  // Narrow builds zero-extend the IR so opcode/funct decode stays well defined.
  logic [31:0] w_ir32;
  generate
    if (DATA_W >= 32) begin : g_ir_wide
      assign w_ir32 = r_ir[31:0];
    end else begin : g_ir_narrow
      assign w_ir32 = {{(32-DATA_W){1'b0}}, r_ir};
    end
  endgenerate

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused_ir;
  assign w_op        = w_ir32[31:26];
  assign w_fn        = w_ir32[5:0];
  assign w_unused_ir = ^w_ir32[25:6];

  logic w_is_load;
  logic w_is_store;
  logic w_is_ov;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_ov    = 1'b0;
    case (w_op)
      6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: w_is_load  = 1'b1;
      6'b101011, 6'b101001, 6'b101000:                       w_is_store = 1'b1;
      6'b001000:                                             w_is_ov    = 1'b1;
      6'b000000: w_is_ov = (w_fn == 6'b100000) || (w_fn == 6'b100010);
      default: begin
      end
    endcase
  end

  logic [EXC_W-1:0] w_exc;

  always_comb begin
    w_exc = '0;
    if (r_valid) begin
      if (r_exc != '0) begin
        w_exc = r_exc;
      end else if (over && w_is_load) begin
        w_exc = EXC_ADEL;
      end else if (over && w_is_store) begin
        w_exc = EXC_ADES;
      end else if (over && w_is_ov) begin
        w_exc = EXC_OV;
      end
    end
  end

  assign exc_e = w_exc;

`ifdef DE_STAGE_PERF_EN
  logic [31:0] r_hold_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt   <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if ((w_act == ACT_HOLD) && (r_hold_cnt != '1)) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
      if (((w_act == ACT_FLUSH) || (w_act == ACT_BUBBLE)) && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign hold_cnt   = r_hold_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_de_stage_reg.sv
// Bench for de_stage_reg: default (32b x5) and narrow (16b x3) instances against a behavioural model.
module tb_de_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        bubble = 1'b0;
  logic        valid_d = 1'b0;
  logic        bd_d = 1'b0;
  logic [4:0]  exc_d = '0;
  logic        over = 1'b0;

  logic [31:0]  ir_d = '0;
  logic [31:0]  pc_d = '0;
  logic [159:0] ch_d = '0;
  logic         valid_e;
  logic [31:0]  ir_e;
  logic [31:0]  pc_e;
  logic         bd_e;
  logic [159:0] ch_e;
  logic [4:0]   exc_e;

  logic [15:0] b_ir_d = '0;
  logic [15:0] b_pc_d = '0;
  logic [47:0] b_ch_d = '0;
  logic        b_valid_e;
  logic [15:0] b_ir_e;
  logic [15:0] b_pc_e;
  logic        b_bd_e;
  logic [47:0] b_ch_e;
  logic [4:0]  b_exc_e;

`ifdef DE_STAGE_PERF_EN
  logic [31:0] hold_cnt, bubble_cnt, b_hold_cnt, b_bubble_cnt;
`endif

  de_stage_reg #(.DATA_W(32), .NUM_CH(5), .EXC_W(5)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .bubble(bubble),
    .valid_d(valid_d), .ir_d(ir_d), .pc_d(pc_d), .bd_d(bd_d), .exc_d(exc_d),
    .ch_d(ch_d), .over(over), .valid_e(valid_e), .ir_e(ir_e), .pc_e(pc_e),
    .bd_e(bd_e), .ch_e(ch_e),
`ifdef DE_STAGE_PERF_EN
    .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt),
`endif
    .exc_e(exc_e)
  );

  de_stage_reg #(.DATA_W(16), .NUM_CH(3), .EXC_W(5)) u_dut_n (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .bubble(bubble),
    .valid_d(valid_d), .ir_d(b_ir_d), .pc_d(b_pc_d), .bd_d(bd_d), .exc_d(exc_d),
    .ch_d(b_ch_d), .over(over), .valid_e(b_valid_e), .ir_e(b_ir_e), .pc_e(b_pc_e),
    .bd_e(b_bd_e), .ch_e(b_ch_e),
`ifdef DE_STAGE_PERF_EN
    .hold_cnt(b_hold_cnt), .bubble_cnt(b_bubble_cnt),
`endif
    .exc_e(b_exc_e)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage contents as plain variables.
  logic         m_valid = 1'b0;
  logic [31:0]  m_ir = '0;
  logic [31:0]  m_pc = '0;
  logic         m_bd = 1'b0;
  logic [4:0]   m_exc = '0;
  logic [159:0] m_ch = '0;
  logic [15:0]  mb_ir = '0;
  logic [15:0]  mb_pc = '0;
  logic [47:0]  mb_ch = '0;
  longint unsigned m_hold_cnt = 0;
  longint unsigned m_bub_cnt  = 0;

  function automatic logic [4:0] exc_of(input logic v, input logic [31:0] ir,
                                        input logic [4:0] ex, input logic ov);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (!v) return 5'd0;
    if (ex != 5'd0) return ex;
    if (!ov) return 5'd0;
    if (op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25}) return 5'd4;
    if (op inside {6'h2b, 6'h29, 6'h28}) return 5'd5;
    if (op == 6'h08 || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22))) return 5'd12;
    return 5'd0;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_ir = '0; m_pc = '0; m_bd = 1'b0; m_exc = '0; m_ch = '0;
    mb_ir = '0; mb_pc = '0; mb_ch = '0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
      m_hold_cnt = 0;
      m_bub_cnt  = 0;
    end else if (flush || (!hold && bubble)) begin
      model_clear();
      if (m_bub_cnt < 64'hFFFF_FFFF) m_bub_cnt++;
    end else if (hold) begin
      if (m_hold_cnt < 64'hFFFF_FFFF) m_hold_cnt++;
    end else begin
      m_valid = valid_d; m_ir = ir_d; m_pc = pc_d; m_bd = bd_d; m_exc = exc_d; m_ch = ch_d;
      mb_ir = b_ir_d; mb_pc = b_pc_d; mb_ch = b_ch_d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_e", 160'(valid_e), 160'(m_valid));
      chk("ir_e", 160'(ir_e), 160'(m_ir));
      chk("pc_e", 160'(pc_e), 160'(m_pc));
      chk("bd_e", 160'(bd_e), 160'(m_bd));
      chk("ch_e", ch_e, m_ch);
      chk("exc_e", 160'(exc_e), 160'(exc_of(m_valid, m_ir, m_exc, over)));
      chk("n_valid_e", 160'(b_valid_e), 160'(m_valid));
      chk("n_ir_e", 160'(b_ir_e), 160'(mb_ir));
      chk("n_pc_e", 160'(b_pc_e), 160'(mb_pc));
      chk("n_ch_e", 160'(b_ch_e), 160'(mb_ch));
      chk("n_exc_e", 160'(b_exc_e), 160'(exc_of(m_valid, {16'h0, mb_ir}, m_exc, over)));
`ifdef DE_STAGE_PERF_EN
      chk("hold_cnt", 160'(hold_cnt), 160'(m_hold_cnt));
      chk("bubble_cnt", 160'(bubble_cnt), 160'(m_bub_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [5:0] ops [13];
    logic [5:0] fns [5];
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25,
            6'h2b, 6'h29, 6'h28, 6'h0f};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2a};
    return {ops[$urandom_range(12)], 20'($urandom), fns[$urandom_range(4)]};
  endfunction

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_valid", 160'(valid_e), 160'(0));
    chk("rst_ir", 160'(ir_e), 160'(0));
    chk("rst_exc", 160'(exc_e), 160'(0));
    tick();
    reset = 1'b0;

    // add with overflow -> Ov
    valid_d = 1'b1; ir_d = 32'h00221020; pc_d = 32'h00003010; exc_d = '0; over = 1'b0;
    tick();
    chk("add_ir", 160'(ir_e), 160'(32'h00221020));
    chk("add_pc", 160'(pc_e), 160'(32'h00003010));
    over = 1'b1;
    #1 chk("add_ov", 160'(exc_e), 160'(12));
    // asynchronous reset between edges
    #1 reset = 1'b1;
    #1;
    chk("amid_ir", 160'(ir_e), 160'(0));
    chk("amid_valid", 160'(valid_e), 160'(0));
    chk("amid_exc", 160'(exc_e), 160'(0));
    reset = 1'b0;

    ir_d = 32'h00221021; over = 1'b0;
    tick();
    over = 1'b1;
    #1 chk("addu_ov", 160'(exc_e), 160'(0));

    ir_d = 32'h8C220004; exc_d = 5'd10;
    tick();
    chk("lw_inherit", 160'(exc_e), 160'(10));
    ir_d = 32'hA0220000; exc_d = '0;
    tick();
    chk("sb_ades", 160'(exc_e), 160'(5));

    over = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ir_d = $urandom; pc_d = $urandom; bd_d = ~bd_d;
      ch_d = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      chk("hold_ir", 160'(ir_e), 160'(32'hA0220000));
      chk("hold_pc", 160'(pc_e), 160'(32'h00003010));
      chk("hold_valid", 160'(valid_e), 160'(1));
    end
    flush = 1'b1;
    tick();
    chk("hf_valid", 160'(valid_e), 160'(0));
    chk("hf_ir", 160'(ir_e), 160'(0));
    chk("hf_ch", ch_e, 160'(0));
`ifdef DE_STAGE_PERF_EN
    chk("hf_hold_cnt", 160'(hold_cnt), 160'(3));
    chk("hf_bubble_cnt", 160'(bubble_cnt), 160'(1));
`endif
    flush = 1'b0; hold = 1'b0;

    bubble = 1'b1; valid_d = 1'b1; ir_d = 32'h8C220004; bd_d = 1'b1;
    b_ch_d = 48'h1111_2222_3333;
    tick();
    chk("bub_ir", 160'(ir_e), 160'(0));
    chk("bub_valid", 160'(valid_e), 160'(0));
    bubble = 1'b0;
    tick();
    chk("rel_ir", 160'(ir_e), 160'(32'h8C220004));
    chk("rel_bd", 160'(bd_e), 160'(1));
    chk("n_ch_full", 160'(b_ch_e), 160'(48'h1111_2222_3333));
    chk("n_ch0", 160'(b_ch_e[15:0]), 160'(16'h3333));

    for (int i = 0; i < 600; i++) begin
      flush   = ($urandom_range(9) == 0);
      hold    = ($urandom_range(4) == 0);
      bubble  = ($urandom_range(4) == 0);
      valid_d = ($urandom_range(3) != 0);
      ir_d    = rand_ir();
      pc_d    = $urandom;
      bd_d    = 1'($urandom);
      exc_d   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
      ch_d    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      b_ir_d  = 16'($urandom);
      b_pc_d  = 16'($urandom);
      b_ch_d  = {16'($urandom), 32'($urandom)};
      over    = 1'($urandom);
      if ($urandom_range(49) == 0) begin
        #2 reset = 1'b1;
        #3 reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/de_stage_reg.md
# de_stage_reg

Parametrised decode-to-execute pipeline register for the five-stage MIPS core. It carries the instruction word, PC, a configurable number of operand channels and the branch-delay flag from D into E. It supports hold (E frozen), bubble (NOP injected behind a stalled D) and flush (exception or eret). In E it produces the stage exception code, merging a code inherited from F/D with the overflow-derived codes for loads, stores and add/sub/addi.

## Interface
Parameters:
- DATA_W, 32, width of IR, PC and each operand channel
- NUM_CH, 5, number of operand channels (e.g. RS, RT, EXT, PC4, PC8)
- EXC_W, 5, exception-code width (codes occupy bits [6:2] of Cause)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears the stage immediately
- flush  input  1  replace stage contents with a bubble next edge
- hold  input  1  keep current contents (E stalled, e.g. mult/div busy)
- bubble  input  1  load a bubble instead of D contents (D stalled)
- valid_d  input  1  D holds a real instruction
- ir_d  input  DATA_W  instruction word from D
- pc_d  input  DATA_W  PC of the D instruction
- bd_d  input  1  D instruction sits in a branch delay slot
- exc_d  input  EXC_W  exception code inherited from F/D (0 = none)
- ch_d  input  NUM_CH*DATA_W  operand channels, channel i at [i*DATA_W +: DATA_W]
- over  input  1  ALU signed-overflow flag for the instruction currently in E
- valid_e  output  1  E holds a real instruction
- ir_e, pc_e  output  DATA_W  registered IR and PC
- bd_e  output  1  registered delay-slot flag
- ch_e  output  NUM_CH*DATA_W  registered operand channels
- exc_e  output  EXC_W  final E-stage exception code, combinational from the registers and over

## Operation
- Each edge takes the highest-priority action that applies: reset > flush > hold > bubble > load.
- Bubble state:
  - valid_e=0, ir_e=0 (sll $0,$0,0), bd_e=0, stored exc=0.
  - pc_e, ch_e are also cleared to 0.
- Reset and flush both produce the bubble state.
- Hold: every register keeps its value, including the stored exc.
- Bubble action: load the bubble state.
- Load action: capture valid_d, ir_d, pc_d, bd_d, exc_d and ch_d.
- exc_e, evaluated in priority order:
  - valid_e=0 → 0.
  - Stored exc ≠ 0 → stored exc (the earlier stage wins).
  - over=1 and opcode in {lw, lb, lbu, lh, lhu} → 4 (AdEL).
  - over=1 and opcode in {sw, sh, sb} → 5 (AdES).
  - over=1 and (opcode 000000 with funct add 100000 or sub 100010, or opcode addi 001000) → 12 (Ov).
  - Otherwise → 0.
- addu, subu, addiu and all other opcodes never raise Ov.
- over is used only combinationally and is never stored.
- NUM_CH=0 is illegal. All channels are independent and unmodified.

## Timing
- Latency is one cycle: D values appear on the E outputs after the next rising edge when the action is load.
- Reset clears the stage asynchronously. All outputs take bubble values immediately; with over=1, exc_e=0.
- flush together with hold: flush wins, so a held instruction is discarded.
- hold together with bubble: hold wins, contents are unchanged and no NOP is injected.
- exc_e updates within the same cycle that over changes. The CP0 samples it in M via the M register.
- A held instruction with an inherited exc keeps reporting that exc every cycle until it is released or flushed.

## Configuration
- DE_STAGE_PERF_EN defined:
  - Adds outputs hold_cnt and bubble_cnt, each 32 bits.
  - hold_cnt increments on each edge whose action is hold.
  - bubble_cnt increments on each edge whose action is bubble or flush.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- DE_STAGE_PERF_EN not defined: the counters and their ports do not exist, and behaviour is otherwise identical.

## Test plan
- Reset mid-run with ir_e=32'h00221020 loaded: assert reset asynchronously between edges → ir_e=0, valid_e=0 and exc_e=0 immediately, before the next edge.
- Load add $2,$1,$2 (32'h00221020, pc_d=32'h00003010, exc_d=0), then drive over=1 → exc_e=12. The same test with addu (32'h00221021) → exc_e=0.
- Load lw (32'h8C220004) with exc_d=4'd10 (RI inherited) and over=1 → exc_e=10. Then load sb (32'hA0220000) with over=1 and exc_d=0 → exc_e=5.
- Hold 3 cycles with changing D inputs → all E outputs are stable. Assert hold+flush together → next edge gives the bubble state. With DE_STAGE_PERF_EN, hold_cnt=3 and bubble_cnt=1.
- Bubble with valid_d=1 and ir_d=32'h8C220004 → ir_e=0 and valid_e=0. On the following load edge → ir_e=32'h8C220004 and bd_e=bd_d.
- NUM_CH=3, DATA_W=16: load ch_d=48'h1111_2222_3333 → ch_e=48'h1111_2222_3333 after one edge. Channel 0 reads 16'h3333.
